// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared register map, bit positions, parity modes and receiver
//                state encoding for the UART receive block.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam logic [1:0] c_addr_data   = 2'd0;
    localparam logic [1:0] c_addr_status = 2'd1;
    localparam logic [1:0] c_addr_ctrl   = 2'd2;

    localparam int c_st_avail     = 0;
    localparam int c_st_ovr       = 1;
    localparam int c_st_ferr      = 2;
    localparam int c_st_perr      = 3;
    localparam int c_st_level_lsb = 4;

    localparam int c_ctrl_thr_msb = 3;
    localparam int c_ctrl_eie     = 6;
    localparam int c_ctrl_flush   = 7;

    localparam int c_par_none = 0;
    localparam int c_par_even = 1;
    localparam int c_par_odd  = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_fifo
//  Description : Power-of-two receive FIFO with flush; a push into a full FIFO
//                only lands when a pop happens in the same cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_fifo
    import uart_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int DEPTH   = 8,
    localparam int c_ptr_w = $clog2(DEPTH),
    localparam int c_cnt_w = $clog2(DEPTH + 1)
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_push,
    input  logic [WIDTH-1:0]   i_push_dat,
    input  logic               i_pop,
    input  logic               i_flush,
    output logic               o_full,
    output logic               o_empty,
    output logic [c_cnt_w-1:0] o_count,
    output logic [WIDTH-1:0]   o_head
);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == c_cnt_w'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & (~o_full | i_pop);
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            // A push coinciding with a flush survives as the only entry.
            r_rd_ptr <= '0;
            r_wr_ptr <= i_push ? c_ptr_w'(1) : '0;
            r_count  <= i_push ? c_cnt_w'(1) : '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            r_count <= r_count + c_cnt_w'(w_do_push) - c_cnt_w'(w_do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_flush && i_push) begin
            r_mem[0] <= i_push_dat;
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : UART receiver (5..8 data bits, optional parity) feeding a
//                receive FIFO, with DATA/STATUS/CTRL bus registers and IRQ.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 434,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [7:0] i_dat,
    output logic [7:0] o_dat,
    input  logic [1:0] i_addr,
    input  logic       i_we,
    input  logic       i_cyc,
    input  logic       rx,
    output logic       o_int
);

    localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);

    rx_state_t          r_state;
    rx_state_t          w_state_next;
    logic               r_rx_meta, r_rx_sync, r_rx_prev;
    logic [15:0]        r_baud_cnt;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic               r_par_err, r_push;
    logic               r_ovr, r_ferr, r_perr, r_eie, r_int;
    logic [3:0]         r_thr;
    logic               w_fall, w_half_hit, w_full_hit, w_cnt_clr;
    logic               w_data_sample, w_par_sample, w_stop_ok, w_stop_bad, w_par_exp;
    logic               w_pop, w_ctrl_wr, w_flush, w_full, w_empty;
    logic [c_cnt_w-1:0] w_count;
    logic [3:0]         w_level;
    logic [7:0]         w_head, w_status, w_ctrl;
    logic               w_unused;

    assign w_fall     = r_rx_prev & ~r_rx_sync;
    assign w_half_hit = (r_baud_cnt == 16'(CLK_DIV / 2));
    assign w_full_hit = (r_baud_cnt == 16'(CLK_DIV - 1));
    assign w_par_exp  = (PARITY == c_par_odd) ? ~(^r_shift) : ^r_shift;
    assign w_pop      = i_cyc & ~i_we & (i_addr == c_addr_data);
    assign w_ctrl_wr  = i_cyc & i_we & (i_addr == c_addr_ctrl);
    assign w_flush    = w_ctrl_wr & i_dat[c_ctrl_flush];
    assign w_level    = 4'(w_count);
    assign w_unused   = ^i_dat[5:4];
    assign o_int      = r_int;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_clr     = 1'b0;
        w_data_sample = 1'b0;
        w_par_sample  = 1'b0;
        w_stop_ok     = 1'b0;
        w_stop_bad    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_clr = 1'b1;
                if (w_fall) w_state_next = ST_START;
            end
            ST_START: begin
                // A line that is high again at mid start bit was a glitch.
                w_cnt_clr = w_half_hit;
                if (w_half_hit) w_state_next = r_rx_sync ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                w_cnt_clr     = w_full_hit;
                w_data_sample = w_full_hit;
                if (w_full_hit && (r_bit_cnt == 3'(DATA_BITS - 1))) begin
                    w_state_next = (PARITY != c_par_none) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                w_cnt_clr    = w_full_hit;
                w_par_sample = w_full_hit;
                if (w_full_hit) w_state_next = ST_STOP;
            end
            ST_STOP: begin
                w_cnt_clr = w_full_hit;
                if (w_full_hit) begin
                    w_stop_ok    = r_rx_sync;
                    w_stop_bad   = ~r_rx_sync;
                    w_state_next = r_rx_sync ? ST_IDLE : ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                w_cnt_clr = 1'b1;
                if (r_rx_sync) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_err  <= 1'b0;
            r_push     <= 1'b0;
            r_ovr      <= 1'b0;
            r_ferr     <= 1'b0;
            r_perr     <= 1'b0;
            r_thr      <= '0;
            r_eie      <= 1'b0;
            r_int      <= 1'b0;
        end else begin
            r_rx_meta  <= rx;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_baud_cnt <= w_cnt_clr ? '0 : r_baud_cnt + 16'd1;
            if (r_state == ST_IDLE && w_fall) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
                r_par_err <= 1'b0;
            end else if (w_data_sample) begin
                r_shift[r_bit_cnt] <= r_rx_sync;
                r_bit_cnt          <= r_bit_cnt + 3'd1;
            end
            if (w_par_sample) r_par_err <= (r_rx_sync != w_par_exp);
            r_push <= w_stop_ok;

            if (w_ctrl_wr) begin
                r_thr <= i_dat[c_ctrl_thr_msb:0];
                r_eie <= i_dat[c_ctrl_eie];
            end
            // Flag sets from receive events take priority over a FLUSH clear.
            r_ovr  <= (r_ovr  & ~w_flush) | (r_push & w_full & ~w_pop & ~w_flush);
            r_ferr <= (r_ferr & ~w_flush) | w_stop_bad;
            r_perr <= (r_perr & ~w_flush) | (r_push & r_par_err);
            r_int  <= ((r_thr != 4'd0) && (w_level >= r_thr)) ||
                      (r_eie && (r_ovr | r_ferr | r_perr));
        end
    end

    uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_push     (r_push),
        .i_push_dat (r_shift),
        .i_pop      (w_pop),
        .i_flush    (w_flush),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count),
        .o_head     (w_head)
    );

    always_comb begin
        w_status = '0;
        w_status[c_st_level_lsb +: 4] = w_level;
        w_status[c_st_perr]  = r_perr;
        w_status[c_st_ferr]  = r_ferr;
        w_status[c_st_ovr]   = r_ovr;
        w_status[c_st_avail] = ~w_empty;
        w_ctrl = '0;
        w_ctrl[c_ctrl_thr_msb:0] = r_thr;
        w_ctrl[c_ctrl_eie]       = r_eie;
        o_dat = '0;
        case (i_addr)
            c_addr_data:   o_dat = w_empty ? 8'h00 : w_head;
            c_addr_status: o_dat = w_status;
            c_addr_ctrl:   o_dat = w_ctrl;
            default:       o_dat = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Scoreboard bench for uart_rx_fifo: stimulus queues expected
//                bus reads / IRQ levels, a negedge monitor pops and compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int c_div = 16;

    typedef struct { logic [7:0] exp; string tag; } rd_exp_t;
    typedef struct { logic       exp; string tag; } int_exp_t;

    logic       clk = 1'b0;
    logic       rst_n, rx_a, rx_b, we, cyc, sel, chk_int;
    logic [1:0] addr;
    logic [7:0] dat;
    logic [7:0] o_dat_a, o_dat_b, cur_dat;
    logic       o_int_a, o_int_b, cur_int, cyc_a, cyc_b;

    rd_exp_t  rd_q[$];
    int_exp_t int_q[$];
    rd_exp_t  m_rd;
    int_exp_t m_int;
    int       errors = 0;
    int       checks = 0;

    always #5 clk = ~clk;

    assign cyc_a   = cyc & ~sel;
    assign cyc_b   = cyc & sel;
    assign cur_dat = sel ? o_dat_b : o_dat_a;
    assign cur_int = sel ? o_int_b : o_int_a;

    uart_rx_fifo #(.CLK_DIV(c_div), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_dat(dat), .o_dat(o_dat_a), .i_addr(addr),
        .i_we(we), .i_cyc(cyc_a), .rx(rx_a), .o_int(o_int_a)
    );

    uart_rx_fifo #(.CLK_DIV(c_div), .DATA_BITS(8), .PARITY(1), .FIFO_DEPTH(8)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_dat(dat), .o_dat(o_dat_b), .i_addr(addr),
        .i_we(we), .i_cyc(cyc_b), .rx(rx_b), .o_int(o_int_b)
    );

    always @(negedge clk) begin
        #1;
        if (cyc && !we) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: o_dat=0x%02h with nothing expected", cur_dat);
            end else begin
                m_rd = rd_q.pop_front();
                if (cur_dat !== m_rd.exp) begin
                    errors++;
                    $display("FAIL %s: o_dat=0x%02h expected 0x%02h", m_rd.tag, cur_dat, m_rd.exp);
                end
            end
        end
        if (chk_int) begin
            checks++;
            if (int_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_int_check: o_int=%0b with nothing expected", cur_int);
            end else begin
                m_int = int_q.pop_front();
                if (cur_int !== m_int.exp) begin
                    errors++;
                    $display("FAIL %s: o_int=%0b expected %0b", m_int.tag, cur_int, m_int.exp);
                end
            end
        end
    end

    task automatic drive_rx(input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [7:0] e, input string tag);
        rd_q.push_back('{e, tag});
        addr = a; we = 1'b0; cyc = 1'b1;
        @(negedge clk);
        cyc = 1'b0;
    endtask

    task automatic bus_read_int(input logic [1:0] a, input logic [7:0] e, input logic ie,
                                input string tag, input string itag);
        rd_q.push_back('{e, tag});
        int_q.push_back('{ie, itag});
        addr = a; we = 1'b0; cyc = 1'b1; chk_int = 1'b1;
        @(negedge clk);
        cyc = 1'b0; chk_int = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        addr = a; dat = d; we = 1'b1; cyc = 1'b1;
        @(negedge clk);
        cyc = 1'b0; we = 1'b0;
    endtask

    task automatic check_int(input logic e, input string tag);
        int_q.push_back('{e, tag});
        chk_int = 1'b1;
        @(negedge clk);
        chk_int = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic has_par, input logic par,
                              input logic stop);
        drive_rx(1'b0);
        repeat (c_div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive_rx(d[i]);
            repeat (c_div) @(negedge clk);
        end
        if (has_par) begin
            drive_rx(par);
            repeat (c_div) @(negedge clk);
        end
        drive_rx(stop);
        repeat (c_div) @(negedge clk);
        drive_rx(1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; we = 1'b0; cyc = 1'b0;
        sel = 1'b0; chk_int = 1'b0; addr = 2'd0; dat = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset values
        bus_read(c_addr_data,   8'h00, "rst_data");
        bus_read(c_addr_status, 8'h00, "rst_status");
        bus_read(c_addr_ctrl,   8'h00, "rst_ctrl");
        bus_read(2'd3,          8'h00, "rst_addr3");
        check_int(1'b0, "rst_int");

        // 0xA5 8N1: STATUS changes exactly two cycles after the stop sample
        fork
            send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
            begin
                repeat (156) @(negedge clk);
                bus_read(c_addr_status, 8'h00, "a5_status_early");
                bus_read(c_addr_status, 8'h11, "a5_status_push");
            end
        join
        repeat (4) @(negedge clk);
        bus_read(c_addr_data,   8'hA5, "a5_data");
        bus_read(c_addr_status, 8'h00, "a5_status_after_pop");

        // Short low glitch, then a good frame
        drive_rx(1'b0);
        repeat (4) @(negedge clk);
        drive_rx(1'b1);
        repeat (30) @(negedge clk);
        bus_read(c_addr_status, 8'h00, "glitch_status");
        check_int(1'b0, "glitch_int");
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        bus_read(c_addr_data, 8'h3C, "post_glitch_data");

        // Framing error with EIE set
        bus_write(c_addr_ctrl, 8'h40);
        bus_read(c_addr_ctrl, 8'h40, "ctrl_eie");
        fork
            send_frame(8'h55, 1'b0, 1'b0, 1'b0);
            begin
                repeat (156) @(negedge clk);
                bus_read_int(c_addr_status, 8'h04, 1'b0, "ferr_status", "ferr_int_lag");
                check_int(1'b1, "ferr_int_rise");
            end
        join
        repeat (4) @(negedge clk);
        bus_read(c_addr_data, 8'h00, "ferr_no_push");
        bus_write(c_addr_ctrl, 8'h80);
        bus_read(c_addr_status, 8'h00, "ferr_flush_status");
        bus_read(c_addr_ctrl,   8'h00, "ferr_flush_ctrl");
        check_int(1'b0, "ferr_flush_int");

        // Overflow of the 4-entry FIFO
        send_frame(8'h11, 1'b0, 1'b0, 1'b1); repeat (4) @(negedge clk);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1); repeat (4) @(negedge clk);
        send_frame(8'h33, 1'b0, 1'b0, 1'b1); repeat (4) @(negedge clk);
        send_frame(8'h44, 1'b0, 1'b0, 1'b1); repeat (4) @(negedge clk);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1); repeat (4) @(negedge clk);
        bus_read(c_addr_status, 8'h43, "ovr_status");
        bus_read(c_addr_data, 8'h11, "ovr_data0");
        bus_read(c_addr_data, 8'h22, "ovr_data1");
        bus_read(c_addr_data, 8'h33, "ovr_data2");
        bus_read(c_addr_data, 8'h44, "ovr_data3");
        bus_read(c_addr_status, 8'h02, "ovr_sticky");
        bus_read(c_addr_data,   8'h00, "empty_data");
        bus_read(c_addr_status, 8'h02, "empty_no_pop");
        bus_write(c_addr_status, 8'hFF);
        bus_write(c_addr_data,   8'hFF);
        bus_read(c_addr_status, 8'h02, "ignored_writes");
        bus_write(c_addr_ctrl, 8'h80);
        bus_read(c_addr_status, 8'h00, "ovr_flush");

        // Threshold interrupt
        bus_write(c_addr_ctrl, 8'h02);
        send_frame(8'h61, 1'b0, 1'b0, 1'b1); repeat (4) @(negedge clk);
        check_int(1'b0, "thr_one_frame");
        send_frame(8'h62, 1'b0, 1'b0, 1'b1); repeat (4) @(negedge clk);
        check_int(1'b1, "thr_two_frames");
        bus_read(c_addr_data, 8'h61, "thr_pop");
        check_int(1'b1, "thr_pop_lag");
        check_int(1'b0, "thr_pop_drop");
        bus_read(c_addr_status, 8'h11, "thr_status");
        bus_read(c_addr_ctrl,   8'h02, "thr_ctrl");

        // Reset in the middle of a frame
        fork
            send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
            begin
                repeat (40) @(negedge clk);
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        bus_read(c_addr_status, 8'h00, "midrst_status");
        bus_read(c_addr_ctrl,   8'h00, "midrst_ctrl");
        bus_read(c_addr_data,   8'h00, "midrst_data");
        check_int(1'b0, "midrst_int");
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1); repeat (4) @(negedge clk);
        bus_read(c_addr_data, 8'h5A, "midrst_next_frame");

        // Even parity instance
        sel = 1'b1;
        send_frame(8'h03, 1'b1, 1'b1, 1'b1); repeat (4) @(negedge clk);
        bus_read(c_addr_status, 8'h19, "par_status");
        bus_read(c_addr_data,   8'h03, "par_data");
        bus_read(c_addr_status, 8'h08, "par_sticky");
        send_frame(8'h07, 1'b1, 1'b1, 1'b1); repeat (4) @(negedge clk);
        bus_read(c_addr_status, 8'h19, "par_good_status");
        bus_read(c_addr_data,   8'h07, "par_good_data");
        bus_write(c_addr_ctrl, 8'h80);
        bus_read(c_addr_status, 8'h00, "par_flush");
        sel = 1'b0;

        repeat (3) @(negedge clk);
        checks++;
        if (rd_q.size() != 0 || int_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations: reads=%0d ints=%0d expected 0 0",
                     rd_q.size(), int_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
